// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: alignment FSM states, control tokens
// and TERC4 codes used by both the decoder and the aligner.
package tmds_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    SLIP,
    SETTLE,
    VERIFY,
    LOCKED
  } align_state_t;

  localparam logic [9:0] CTRL_TOKEN [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100,
    10'b1001100011,
    10'b1011100100,
    10'b1011100010,
    10'b0101110001,
    10'b0100011110,
    10'b0110001110,
    10'b0100111100,
    10'b1011001100,
    10'b0100111001,
    10'b0110011100,
    10'b1011000110,
    10'b1010001110,
    10'b1001110001,
    10'b0101100011,
    10'b1011000011
  };

endpackage

// File: rtl/tmds_sync_window.sv
// Control-run detector and observation window for TMDS alignment.
// win_hit includes a run completing on the window's last cycle.
module tmds_sync_window #(
  parameter int SYNC_WINDOW = 2048,
  parameter int MIN_RUN     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic sync_valid,
  output logic win_end,
  output logic win_hit
);

  localparam int WW = $clog2(SYNC_WINDOW);
  localparam int RW = $clog2(MIN_RUN + 1);
  localparam logic [WW-1:0] WLAST = WW'(SYNC_WINDOW - 1);
  localparam logic [RW-1:0] RMAX  = RW'(MIN_RUN);

  logic [WW-1:0] wcnt;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          hit;

  always_comb begin
    run_nxt = '0;
    if (sync_valid)
      run_nxt = (run == RMAX) ? RMAX : run + 1'b1;
  end

  assign win_end = !clear && (wcnt == WLAST);
  assign win_hit = hit || (run_nxt == RMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
      run  <= '0;
      hit  <= 1'b0;
    end else if (clear) begin
      wcnt <= '0;
      run  <= '0;
      hit  <= 1'b0;
    end else begin
      run  <= run_nxt;
      wcnt <= win_end ? '0 : wcnt + 1'b1;
      hit  <= win_end ? 1'b0 : win_hit;
    end
  end

endmodule

// File: rtl/tmds_align_ctrl.sv
// Word-alignment controller for one TMDS channel: slips the
// deserializer until control periods decode, then tracks lock.
module tmds_align_ctrl
  import tmds_pkg::*;
#(
  parameter int SYNC_WINDOW = 2048,
  parameter int MIN_RUN     = 8,
  parameter int SLIP_SETTLE = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int LOSS_COUNT  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sync_valid,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_count,
  output logic       slip_wrap
);

  localparam int GW = $clog2(LOCK_COUNT) + 1;
  localparam int MW = $clog2(LOSS_COUNT) + 1;
  localparam int SW = $clog2(SLIP_SETTLE) + 1;
  localparam logic [GW-1:0] GLOCK = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MLOSS = MW'(LOSS_COUNT);
  localparam logic [SW-1:0] SLAST = SW'(SLIP_SETTLE - 1);

  align_state_t  state;
  logic [GW-1:0] good;
  logic [MW-1:0] miss;
  logic [SW-1:0] scnt;
  logic          en_q;
  logic          clear;
  logic          win_end;
  logic          win_hit;
  logic          do_slip;

  // Window restarts the cycle after enable is first seen high.
  assign clear = !enable || !en_q ||
                 (state == SLIP) || (state == SETTLE);

  tmds_sync_window #(
    .SYNC_WINDOW(SYNC_WINDOW),
    .MIN_RUN    (MIN_RUN)
  ) u_win (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .sync_valid(sync_valid),
    .win_end   (win_end),
    .win_hit   (win_hit)
  );

  always_comb begin
    do_slip = 1'b0;
    if (enable && win_end && !win_hit) begin
      unique case (state)
        SEARCH, VERIFY: do_slip = 1'b1;
        LOCKED:  do_slip = (miss + 1'b1 == MLOSS);
        default: do_slip = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      good       <= '0;
      miss       <= '0;
      scnt       <= '0;
      en_q       <= 1'b0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      slip_count <= '0;
      slip_wrap  <= 1'b0;
    end else begin
      en_q      <= enable;
      bitslip   <= 1'b0;
      slip_wrap <= 1'b0;
      if (!enable) begin
        state  <= SEARCH;
        good   <= '0;
        miss   <= '0;
        scnt   <= '0;
        locked <= 1'b0;
      end else if (do_slip) begin
        state      <= SLIP;
        good       <= '0;
        miss       <= '0;
        locked     <= 1'b0;
        bitslip    <= 1'b1;
        slip_wrap  <= (slip_count == 4'd9);
        slip_count <= (slip_count == 4'd9) ? 4'd0
                                           : slip_count + 4'd1;
      end else begin
        unique case (state)
          SEARCH: if (win_end) begin
            state <= VERIFY;
            good  <= GW'(1);
          end
          VERIFY: if (win_end) begin
            if (good + 1'b1 == GLOCK) begin
              state  <= LOCKED;
              locked <= 1'b1;
              miss   <= '0;
            end
            good <= good + 1'b1;
          end
          LOCKED: if (win_end) begin
            miss <= win_hit ? '0 : miss + 1'b1;
          end
          SLIP: begin
            state <= SETTLE;
            scnt  <= '0;
          end
          SETTLE: begin
            if (scnt == SLAST)
              state <= SEARCH;
            else
              scnt <= scnt + 1'b1;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Scoreboard bench for tmds_align_ctrl: expected slip and lock
// events are queued per scenario and matched as the DUT emits them.
module tb_tmds_align_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       sync_valid;
  logic       bitslip;
  logic       locked;
  logic [3:0] slip_count;
  logic       slip_wrap;

  tmds_align_ctrl #(
    .SYNC_WINDOW(64),
    .MIN_RUN    (8),
    .SLIP_SETTLE(4),
    .LOCK_COUNT (2),
    .LOSS_COUNT (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .sync_valid(sync_valid),
    .bitslip   (bitslip),
    .locked    (locked),
    .slip_count(slip_count),
    .slip_wrap (slip_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int sl;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  t0       = 0;
  int  n        = 0;
  int  mode     = 0;
  logic prev_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pat(int m, int x);
    case (m)
      1: return (x <= 120) ? (x % 40 < 10) : (x >= 200 && x <= 209);
      2: return (x % 20 < 7);
      3: return (x > 202) && (x % 40 < 10);
      4: return (x >= 57 && x <= 64) || (x >= 80 && x <= 89) ||
                (x >= 186 && x <= 193);
      5: return (x > 64) && (x % 40 < 10);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic push(int k, int sl, int v);
    ev_t e;
    e.k   = k;
    e.sl  = sl;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(int k, int sl, int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_cycle", k, -1);
    end else begin
      e = exp_q.pop_front();
      chk("ev_cycle", k, e.k);
      chk("ev_kind", sl, e.sl);
      chk("ev_val", v, e.val);
    end
  endtask

  // Events are observed on the falling edge after rising edge k.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_locked = 1'b0;
    end else begin
      if (bitslip || slip_wrap)
        got_ev(cyc - t0, 1, {27'd0, slip_wrap, slip_count});
      if (locked != prev_locked)
        got_ev(cyc - t0, 0, {31'd0, locked});
      prev_locked = locked;
    end
  end

  task automatic do_reset();
    enable     = 1'b0;
    sync_valid = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start(int m);
    @(negedge clk);
    mode       = m;
    t0         = cyc + 1;
    n          = 0;
    enable     = 1'b1;
    sync_valid = pat(m, 0);
  endtask

  task automatic run_to(int x);
    while (n < x) begin
      @(negedge clk);
      n          = cyc - t0 + 1;
      sync_valid = pat(mode, n);
    end
  endtask

  task automatic end_scn(string tag);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
    do_reset();
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    sync_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_slip_count", slip_count, 0);
    chk("rst_slip_wrap", slip_wrap, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // clean lock, a single miss window, then loss
    push(128, 0, 1);
    push(384, 1, 1);
    push(384, 0, 0);
    start(1);
    run_to(200);
    chk("s1_locked", locked, 1);
    chk("s1_slip_count", slip_count, 0);
    run_to(390);
    end_scn("s1_pending");

    // short runs only: periodic slips and wrap
    for (int j = 1; j <= 10; j++)
      push(64 + 69 * (j - 1), 1, (j == 10) ? 16 : j);
    start(2);
    run_to(700);
    chk("s2_locked", locked, 0);
    end_scn("s2_pending");

    // bursts appear only after the third slip
    push(64, 1, 1);
    push(133, 1, 2);
    push(202, 1, 3);
    push(335, 0, 1);
    start(3);
    run_to(340);
    chk("s3_slip_count", slip_count, 3);
    end_scn("s3_pending");

    // boundary runs at window cycle 63 and cycle 0
    push(128, 0, 1);
    push(384, 1, 1);
    push(384, 0, 0);
    start(4);
    run_to(390);
    end_scn("s4_pending");

    // enable dropped in VERIFY, then re-enabled
    push(64, 1, 1);
    push(378, 0, 1);
    start(5);
    run_to(150);
    enable = 1'b0;
    run_to(200);
    chk("s5_locked_off", locked, 0);
    chk("s5_slip_held", slip_count, 1);
    chk("s5_no_slip", bitslip, 0);
    run_to(250);
    enable = 1'b1;
    run_to(380);
    chk("s5_slip_count", slip_count, 1);
    end_scn("s5_pending");

    // async reset in the middle of SETTLE
    push(64, 1, 1);
    start(6);
    run_to(67);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_slip_count", slip_count, 0);
    chk("s6_rst_bitslip", bitslip, 0);
    chk("s6_rst_locked", locked, 0);
    chk("s6_rst_slip_wrap", slip_wrap, 0);
    end_scn("s6_pending");

    // async reset during the bitslip pulse itself
    push(64, 1, 1);
    start(6);
    run_to(65);
    #1 reset_n = 1'b0;
    #1;
    chk("s7_rst_inflight_bitslip", bitslip, 0);
    chk("s7_rst_slip_count", slip_count, 0);
    end_scn("s7_pending");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
